// File: rtl/sdhci_cmd_pkg.sv
// Shared types and constants for the SD command-line sequencer.
package sdhci_cmd_pkg;

   // Response type, encoded as in the SDHCI Command register.
   typedef enum logic [1:0] {
      RESP_NONE    = 2'b00,
      RESP_136     = 2'b01,
      RESP_48      = 2'b10,
      RESP_48_BUSY = 2'b11
   } resp_type_e;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      TX_WAIT,
      RSP_WAIT,
      GAP,
      DRAIN
   } seq_state_e;

   localparam logic [5:0] CMD12_IDX = 6'd12;

endpackage

// File: rtl/counter.sv
// Up-counter with synchronous clear (priority) and count enable.
module counter #(
   parameter int unsigned Width = 7
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             en_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] count_q, count_d;

   // Next count: clear wins over increment.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/cmd_sequencer.sv
// Arbitrates host vs auto-CMD12, launches cmd_write, supervises the response
// (NCR timeout) and enforces the NCC/NRC gap before the next command.
module cmd_sequencer
   import sdhci_cmd_pkg::*;
#(
   parameter int unsigned NccCycles  = 8,
   parameter int unsigned RspTimeout = 64,
   parameter int unsigned CntWidth   = 7
) (
   input  logic        sd_freq_clk_i,
   input  logic        rst_i,
   input  logic        host_valid_i,
   output logic        host_ready_o,
   input  logic [5:0]  host_nr_i,
   input  logic [31:0] host_arg_i,
   input  logic [1:0]  host_rsp_i,
   input  logic        auto12_valid_i,
   output logic        auto12_ready_o,
   input  logic        abort_i,
   output logic        start_tx_o,
   output logic [5:0]  cmd_nr_o,
   output logic [31:0] cmd_argument_o,
   input  logic        tx_done_i,
   output logic        rsp_en_o,
   output logic        rsp_long_o,
   input  logic        rsp_started_i,
   input  logic        rsp_done_i,
   input  logic        rsp_err_i,
   output logic        cmd_inhibit_o,
   output logic        is_auto12_o,
   output logic        cmd_complete_o,
   output logic        rsp_timeout_o,
   output logic        rsp_error_o
);

   localparam logic [CntWidth-1:0] GapLast = CntWidth'(NccCycles - 1);
   localparam logic [CntWidth-1:0] RspLast = CntWidth'(RspTimeout - 1);

   seq_state_e    state_q, state_d;
   logic [5:0]    nr_q, nr_d;
   logic [31:0]   arg_q, arg_d;
   resp_type_e    rsp_q, rsp_d;
   logic          auto12_q, auto12_d;
   logic          started_q, started_d;
   logic          start_tx_q, start_tx_d;
   logic          rsp_en_q, rsp_en_d;
   logic          rsp_long_q, rsp_long_d;
   logic          inhibit_q, inhibit_d;
   logic          complete_q, complete_d;
   logic          timeout_q, timeout_d;
   logic          error_q, error_d;

   logic                can_accept;
   logic                timeout_hit;
   logic                cnt_clear;
   logic                cnt_en;
   logic [CntWidth-1:0] cnt;

   // Grants are combinational so the requester sees acceptance in the same cycle.
   assign can_accept     = (state_q == IDLE) && tx_done_i && !abort_i && !rst_i;
   assign auto12_ready_o = can_accept && auto12_valid_i;
   assign host_ready_o   = can_accept && host_valid_i && !auto12_valid_i;

   assign timeout_hit = (cnt == RspLast) && !started_q && !rsp_started_i;

   // One counter serves both the NCR timeout and the gap; restart it on entry.
   always_comb begin
      cnt_clear = (state_d != state_q) && ((state_d == GAP) || (state_d == RSP_WAIT));
      cnt_en    = (state_q == GAP) ||
                  ((state_q == RSP_WAIT) && !started_q && !rsp_started_i);
   end

   counter #(
      .Width (CntWidth)
   ) u_counter (
      .clk_i   (sd_freq_clk_i),
      .rst_i   (rst_i),
      .clear_i (cnt_clear),
      .en_i    (cnt_en),
      .count_o (cnt)
   );

   // Next-state, latched command fields and registered output values.
   always_comb begin
      state_d    = state_q;
      nr_d       = nr_q;
      arg_d      = arg_q;
      rsp_d      = rsp_q;
      auto12_d   = auto12_q;
      started_d  = started_q;
      complete_d = 1'b0;
      timeout_d  = 1'b0;
      error_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (auto12_ready_o) begin
               nr_d     = CMD12_IDX;
               arg_d    = '0;
               rsp_d    = RESP_48_BUSY;
               auto12_d = 1'b1;
               state_d  = LAUNCH;
            end else if (host_ready_o) begin
               nr_d     = host_nr_i;
               arg_d    = host_arg_i;
               rsp_d    = resp_type_e'(host_rsp_i);
               auto12_d = 1'b0;
               state_d  = LAUNCH;
            end
         end
         LAUNCH: state_d = TX_WAIT;
         TX_WAIT: begin
            if (tx_done_i) begin
               if (rsp_q == RESP_NONE) begin
                  complete_d = 1'b1;
                  state_d    = GAP;
               end else begin
                  started_d = 1'b0;
                  state_d   = RSP_WAIT;
               end
            end
         end
         RSP_WAIT: begin
            if (rsp_started_i) begin
               started_d = 1'b1;
            end
            // A finished response beats a timeout landing in the same cycle.
            if (rsp_done_i) begin
               complete_d = 1'b1;
               error_d    = rsp_err_i;
               state_d    = GAP;
            end else if (timeout_hit) begin
               timeout_d = 1'b1;
               state_d   = GAP;
            end
         end
         GAP: begin
            if (cnt == GapLast) begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (tx_done_i) begin
               state_d = GAP;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort: no events; let cmd_write finish its frame before the gap.
      if (abort_i) begin
         complete_d = 1'b0;
         timeout_d  = 1'b0;
         error_d    = 1'b0;
         if ((state_q == LAUNCH) || (state_q == TX_WAIT) || (state_q == RSP_WAIT)) begin
            state_d = ((state_q == LAUNCH) || !tx_done_i) ? DRAIN : GAP;
         end
      end

      start_tx_d = (state_d == LAUNCH);
      rsp_en_d   = (state_d == RSP_WAIT);
      rsp_long_d = (state_d == RSP_WAIT) && (rsp_d == RESP_136);
      inhibit_d  = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge sd_freq_clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         nr_q       <= '0;
         arg_q      <= '0;
         rsp_q      <= RESP_NONE;
         auto12_q   <= 1'b0;
         started_q  <= 1'b0;
         start_tx_q <= 1'b0;
         rsp_en_q   <= 1'b0;
         rsp_long_q <= 1'b0;
         inhibit_q  <= 1'b0;
         complete_q <= 1'b0;
         timeout_q  <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         nr_q       <= nr_d;
         arg_q      <= arg_d;
         rsp_q      <= rsp_d;
         auto12_q   <= auto12_d;
         started_q  <= started_d;
         start_tx_q <= start_tx_d;
         rsp_en_q   <= rsp_en_d;
         rsp_long_q <= rsp_long_d;
         inhibit_q  <= inhibit_d;
         complete_q <= complete_d;
         timeout_q  <= timeout_d;
         error_q    <= error_d;
      end
   end

   assign start_tx_o     = start_tx_q;
   assign cmd_nr_o       = nr_q;
   assign cmd_argument_o = arg_q;
   assign rsp_en_o       = rsp_en_q;
   assign rsp_long_o     = rsp_long_q;
   assign cmd_inhibit_o  = inhibit_q;
   assign is_auto12_o    = auto12_q;
   assign cmd_complete_o = complete_q;
   assign rsp_timeout_o  = timeout_q;
   assign rsp_error_o    = error_q;

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Sequences the SD command-line transmitter (`cmd_write`) and arbitrates between two command sources: the host command register and auto-CMD12 from the data path.
- Latches the winning command and launches one transmission.
- Enables the response receiver and enforces the response timeout (NCR) and the inter-command gaps (NCC/NRC).
- Drives the Command Inhibit (CMD) status and the completion/error event pulses.

Parameters:
- NccCycles, 8, minimum idle sd clocks between end of one command/response and the next start bit.
- RspTimeout, 64, max sd clocks from command end bit to response start bit before a timeout error.
- CntWidth, 7, width of the shared gap/timeout counter; must hold max(NccCycles, RspTimeout).

Ports:
- sd_freq_clk_i  in  1  SD-frequency clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- host_valid_i  in  1  host command request.
- host_ready_o  out  1  host request accepted this cycle.
- host_nr_i  in  6  host command index.
- host_arg_i  in  32  host argument.
- host_rsp_i  in  2  host response type (resp_type_e).
- auto12_valid_i  in  1  auto-CMD12 request; index fixed to 12, argument 0, response RESP_48_BUSY.
- auto12_ready_o  out  1  auto-CMD12 accepted.
- abort_i  in  1  software reset of the CMD line.
- start_tx_o  out  1  one-cycle start pulse to `cmd_write`.
- cmd_nr_o  out  6  latched index to `cmd_write`.
- cmd_argument_o  out  32  latched argument to `cmd_write`.
- tx_done_i  in  1  `cmd_write` idle indication.
- rsp_en_o  out  1  enables the response receiver.
- rsp_long_o  out  1  selects 136-bit response framing.
- rsp_started_i  in  1  receiver saw the response start bit.
- rsp_done_i  in  1  receiver finished the response (one-cycle pulse).
- rsp_err_i  in  1  CRC/end-bit/index error, valid with rsp_done_i.
- cmd_inhibit_o  out  1  Command Inhibit (CMD) status.
- is_auto12_o  out  1  the in-flight command came from auto12.
- cmd_complete_o  out  1  one-cycle completion pulse.
- rsp_timeout_o  out  1  one-cycle timeout pulse.
- rsp_error_o  out  1  one-cycle response-error pulse.

Behaviour:
- Reset: state IDLE, counter 0, every output 0 (cmd_nr_o, cmd_argument_o, readies, pulses, inhibit, is_auto12_o). Reset mid-operation returns to IDLE immediately; `cmd_write` is reset by the same reset.
- IDLE:
  - Accept when tx_done_i=1 and abort_i=0.
  - Priority: auto12 over host. Only one ready asserted per cycle.
  - On accept, latch nr/arg/rsp type and is_auto12_o, and go to LAUNCH.
  - The unaccepted requester must hold valid; no request is dropped.
- LAUNCH (1 cycle): start_tx_o=1. Next state is TX_WAIT.
- TX_WAIT:
  - `cmd_write` drops tx_done_i on the cycle after start, so TX_WAIT treats tx_done_i=1 as end of transmission.
  - If rsp type is RESP_NONE, pulse cmd_complete_o and go to GAP.
  - Otherwise clear the counter and go to RSP_WAIT.
- RSP_WAIT:
  - rsp_en_o=1; rsp_long_o=(rsp==RESP_136).
  - Counter increments each cycle until rsp_started_i, then freezes.
  - Counter reaching RspTimeout-1 with no start seen: pulse rsp_timeout_o and go to GAP.
  - rsp_done_i: pulse cmd_complete_o; also pulse rsp_error_o if rsp_err_i; go to GAP.
  - rsp_done_i and timeout in the same cycle: done wins.
  - Busy (RESP_48_BUSY) is treated as RESP_48 here; DAT0 busy wait is owned by the data path.
- GAP: counter cleared on entry; leave to IDLE when the counter reaches NccCycles-1, i.e. exactly NccCycles cycles in GAP.
- cmd_inhibit_o=1 in every state except IDLE. It deasserts the cycle GAP exits.
- abort_i:
  - In any state, clear rsp_en_o and suppress all pulses from that cycle on.
  - If tx_done_i=0 (or in LAUNCH), go to DRAIN, which waits for tx_done_i=1 and then enters GAP.
  - Otherwise go straight to GAP.
  - In IDLE it blocks acceptance.
- Latched command fields hold their values until the next accept.

Decomposition:
- Package sdhci_cmd_pkg holds:
  - resp_type_e: RESP_NONE=2'b00, RESP_136=2'b01, RESP_48=2'b10, RESP_48_BUSY=2'b11, matching the SDHCI Command register encoding.
  - seq_state_e: IDLE, LAUNCH, TX_WAIT, RSP_WAIT, GAP, DRAIN.
  - constant CMD12_IDX=6'd12.
- Gap/timeout counting reuses the existing `counter` module (clear/en controlled by the FSM). No new sub-module.

Test Plan:
- Host CMD0 with RESP_NONE -> one start_tx_o pulse, cmd_nr_o=0; cmd_complete_o one cycle after tx_done_i rises; cmd_inhibit_o low exactly 8 cycles later.
- Host CMD17 arg 0x0000_0200 with RESP_48, rsp_started_i after 10 cycles, rsp_done_i with rsp_err_i=1 -> cmd_complete_o and rsp_error_o pulse together; rsp_en_o high only in RSP_WAIT.
- Host CMD8 with RESP_48 and no response -> rsp_timeout_o exactly 64 cycles after TX_WAIT exit; no cmd_complete_o.
- Host and auto12 valid in the same IDLE cycle -> auto12 granted (cmd_nr_o=12, arg 0, is_auto12_o=1); host granted after the auto12 GAP with its fields intact.
- abort_i during TX_WAIT -> no pulses; DRAIN until tx_done_i=1, then 8 GAP cycles; next host request then accepted.
- rst_i asserted in RSP_WAIT -> next cycle IDLE, all outputs 0, host_ready_o=1 the cycle after release if host_valid_i=1.
